// File: rtl/bus_cycle_ctrl.sv
// 8085-style machine-cycle sequencer: one latched request becomes T1-T2-[TW]-T3-[T4]
// on a split (in/out/oe) multiplexed AD bus, with READY stretching, timeout and HOLD/HLDA.
module bus_cycle_ctrl #(
  parameter int         MAX_WAIT = 15,
  parameter logic [7:0] TMO_DATA = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [2:0]  cmd,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        done,
  output logic        err,
  output logic        busy,
  input  logic [7:0]  ad_in,
  output logic [7:0]  ad_out,
  output logic        ad_oe,
  output logic [7:0]  a_hi,
  output logic        ale,
  output logic        RDn,
  output logic        WRn,
  output logic        IO_Mn,
  output logic        S0,
  output logic        S1,
  output logic        ctl_oe,
  input  logic        READY,
  input  logic        HOLD,
  output logic        HLDA,
  output logic [2:0]  fsm_state
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] T1     = 3'd1;
  localparam logic [2:0] T2     = 3'd2;
  localparam logic [2:0] TW     = 3'd3;
  localparam logic [2:0] T3     = 3'd4;
  localparam logic [2:0] T4     = 3'd5;
  localparam logic [2:0] HOLDST = 3'd6;

  localparam logic [2:0] CMD_FETCH = 3'b000;
  localparam logic [2:0] CMD_MRD   = 3'b001;
  localparam logic [2:0] CMD_MWR   = 3'b010;
  localparam logic [2:0] CMD_IORD  = 3'b011;
  localparam logic [2:0] CMD_IOWR  = 3'b100;

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [2:0]    cmd_q;
  logic [15:0]   addr_q;
  logic [7:0]    wdata_q;
  logic [CW-1:0] wait_cnt;
  logic          tmo;
  logic          hlda;

  logic          cmd_legal;
  logic          in_cycle;
  logic          strobe_phase;
  logic          q_read;
  logic          q_write;

  function automatic logic is_read(input logic [2:0] c);
    return (c == CMD_FETCH) || (c == CMD_MRD) || (c == CMD_IORD);
  endfunction

  function automatic logic is_write(input logic [2:0] c);
    return (c == CMD_MWR) || (c == CMD_IOWR);
  endfunction

  function automatic logic is_io(input logic [2:0] c);
    return (c == CMD_IORD) || (c == CMD_IOWR);
  endfunction

  assign cmd_legal = (cmd <= CMD_IOWR);

  // HOLD is only honoured between cycles, and wins over a same-cycle req.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (HOLD)                 state_nxt = HOLDST;
        else if (req && cmd_legal) state_nxt = T1;
      end
      T1:     state_nxt = T2;
      T2:     state_nxt = READY ? T3 : TW;
      TW: begin
        if (READY || (wait_cnt == WAIT_LIMIT)) state_nxt = T3;
      end
      T3:     state_nxt = (cmd_q == CMD_FETCH) ? T4 : IDLE;
      T4:     state_nxt = IDLE;
      HOLDST: begin
        if (!HOLD) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cmd_q    <= 3'b000;
      addr_q   <= 16'h0000;
      wdata_q  <= 8'h00;
      wait_cnt <= '0;
      tmo      <= 1'b0;
      rdata    <= 8'h00;
      done     <= 1'b0;
      err      <= 1'b0;
      hlda     <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      err   <= 1'b0;
      // HLDA lags HOLDST entry by one cycle but drops on the same edge as the exit.
      hlda  <= (state == HOLDST) && HOLD;
      case (state)
        IDLE: begin
          if (!HOLD && req) begin
            if (cmd_legal) begin
              cmd_q    <= cmd;
              addr_q   <= addr;
              wdata_q  <= wdata;
              tmo      <= 1'b0;
              wait_cnt <= '0;
            end else begin
              done <= 1'b1;
              err  <= 1'b1;
            end
          end
        end
        T2: begin
          if (!READY) wait_cnt <= CW'(1);
        end
        TW: begin
          if (!READY) begin
            if (wait_cnt == WAIT_LIMIT) tmo <= 1'b1;
            else                        wait_cnt <= wait_cnt + CW'(1);
          end
        end
        T3: begin
          done <= 1'b1;
          err  <= tmo;
          if (is_read(cmd_q)) rdata <= tmo ? TMO_DATA : ad_in;
        end
        default: ;
      endcase
    end
  end

  assign q_read       = is_read(cmd_q);
  assign q_write      = is_write(cmd_q);
  assign in_cycle     = (state == T1) || (state == T2) || (state == TW) ||
                        (state == T3) || (state == T4);
  assign strobe_phase = (state == T2) || (state == TW) || (state == T3);

  always_comb begin
    ad_out = 8'h00;
    if (state == T1)                   ad_out = addr_q[7:0];
    else if (strobe_phase && q_write)  ad_out = wdata_q;
  end

  assign ad_oe     = (state == T1) || (strobe_phase && q_write);
  assign ale       = (state == T1);
  assign RDn       = !(strobe_phase && q_read);
  assign WRn       = !(strobe_phase && q_write);
  assign a_hi      = addr_q[15:8];
  assign IO_Mn     = in_cycle && is_io(cmd_q);
  assign S1        = in_cycle && q_read;
  assign S0        = in_cycle && ((cmd_q == CMD_FETCH) || q_write);
  assign ctl_oe    = (state != HOLDST);
  assign busy      = (state != IDLE);
  assign HLDA      = hlda;
  assign fsm_state = state;

endmodule
